// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per clock, LSB first, result registered on completion.
// Optional carry-in port enabled by defining SERIAL_ADDER_CIN_EN.
module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_CIN_EN
  input  logic             cin,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             carry_seed;
  logic [1:0]       fa;
  logic [WIDTH-1:0] sum_shift;

`ifdef SERIAL_ADDER_CIN_EN
  assign carry_seed = cin;
`else
  assign carry_seed = 1'b0;
`endif

  // Returns {carry_out, sum_bit}
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    return {(x & y) | (x & c) | (y & c), x ^ y ^ c};
  endfunction

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    sum_sh_d  = sum_sh_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    fa        = full_add(a_sh_q[0], b_sh_q[0], carry_q);
    sum_shift = sum_sh_q >> 1;
    sum_shift[WIDTH-1] = fa[0];

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          sum_sh_d = '0;
          carry_d  = carry_seed;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = sum_shift;
        carry_d  = fa[1];
        cnt_d    = cnt_q + CW'(1);
        // The last bit is folded straight into the result so done appears with it.
        if (cnt_q == LAST) begin
          sum_d   = sum_shift;
          cout_d  = fa[1];
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=4 and WIDTH=1 instances against a latency/arithmetic model.
module tb_serial_adder;

`ifdef SERIAL_ADDER_CIN_EN
  localparam bit CIN_EN = 1'b1;
`else
  localparam bit CIN_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start4, start1;
  logic [3:0] a4, b4, sum4;
  logic [0:0] a1, b1, sum1;
  logic       cin4, cin1;
  logic       busy4, done4, cout4;
  logic       busy1, done1, cout1;

  int ncmp = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  int              m_left [2];
  longint unsigned m_pend [2];
  longint unsigned m_sum  [2];
  bit              m_cout [2];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
`ifdef SERIAL_ADDER_CIN_EN
    .cin(cin4),
`endif
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
`ifdef SERIAL_ADDER_CIN_EN
    .cin(cin1),
`endif
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted start yields done WIDTH edges later, busy in between, then one idle edge.
  task automatic model_step(input int i, input int w, input bit r, input bit st,
                            input longint unsigned av, input longint unsigned bv, input bit cv);
    if (r) begin
      m_left[i] = 0;
      m_sum[i]  = 0;
      m_cout[i] = 1'b0;
    end else if (m_left[i] == 0) begin
      if (st) begin
        m_left[i] = w + 1;
        m_pend[i] = av + bv + longint'(cv);
      end
    end else begin
      m_left[i]--;
      if (m_left[i] == 1) begin
        m_sum[i]  = m_pend[i] & ((64'd1 << w) - 1);
        m_cout[i] = ((m_pend[i] >> w) & 1) != 0;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, 4, rst, start4, a4, b4, CIN_EN ? cin4 : 1'b0);
    model_step(1, 1, rst, start1, a1, b1, CIN_EN ? cin1 : 1'b0);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy4", busy4, m_left[0] > 1);
      chk("done4", done4, m_left[0] == 1);
      chk("sum4",  sum4,  m_sum[0]);
      chk("cout4", cout4, m_cout[0]);
      chk("busy1", busy1, m_left[1] > 1);
      chk("done1", done1, m_left[1] == 1);
      chk("sum1",  sum1,  m_sum[1]);
      chk("cout1", cout1, m_cout[1]);
    end
  end

  task automatic op4(input logic [3:0] av, input logic [3:0] bv, input logic cv,
                     input bit hold, output int lat, output int nbusy);
    @(negedge clk);
    a4 = av; b4 = bv; cin4 = cv; start4 = 1'b1;
    @(negedge clk);
    start4 = hold;
    a4 = hold ? 4'd1 : 4'($urandom);
    b4 = hold ? 4'd1 : 4'($urandom);
    cin4 = 1'($urandom);
    lat = 0; nbusy = 0;
    while (!done4 && lat < 20) begin
      if (busy4) nbusy++;
      @(negedge clk);
      lat++;
    end
    start4 = 1'b0;
  endtask

  task automatic op1(input logic av, input logic bv, output int lat);
    @(negedge clk);
    a1 = av; b1 = bv; cin1 = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; a1 = ~av; b1 = ~bv;
    lat = 0;
    while (!done1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  int lat, nbusy, ndone;

  initial begin
    rst = 1'b1; start4 = 0; start1 = 0;
    a4 = 0; b4 = 0; cin4 = 0; a1 = 0; b1 = 0; cin1 = 0;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_sum",  sum4, 0);
    chk("rst_cout", cout4, 0);
    rst = 1'b0;

    // 7 + 9 = 16 -> sum 0, carry 1
    op4(4'd7, 4'd9, 1'b0, 1'b0, lat, nbusy);
    chk("lat_7p9", lat, 4);
    chk("busycyc_7p9", nbusy, 4);
    chk("sum_7p9", sum4, 0);
    chk("cout_7p9", cout4, 1);
    chk("model_sum_7p9", m_sum[0], 0);

    op4(4'd15, 4'd15, 1'b0, 1'b0, lat, nbusy);
    chk("sum_15p15", sum4, 14);
    chk("cout_15p15", cout4, 1);
    repeat (5) @(negedge clk);
    chk("hold_sum", sum4, 14);
    chk("hold_cout", cout4, 1);
    op4(4'd3, 4'd4, 1'b0, 1'b0, lat, nbusy);
    chk("sum_3p4", sum4, 7);
    chk("cout_3p4", cout4, 0);

    // start held high through RUN with different operands
    op4(4'd5, 4'd6, 1'b0, 1'b1, lat, nbusy);
    chk("held_sum", sum4, 11);
    chk("held_cout", cout4, 0);
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (done4) ndone++;
    end
    chk("held_extra_done", ndone, 0);
    chk("held_idle_busy", busy4, 0);

    // reset at the second RUN edge
    @(negedge clk);
    a4 = 4'd9; b4 = 4'd2; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy4, 0);
    chk("abort_done", done4, 0);
    chk("abort_sum",  sum4, 0);
    chk("abort_cout", cout4, 0);
    rst = 1'b0;
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (done4) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    op4(4'd9, 4'd2, 1'b0, 1'b0, lat, nbusy);
    chk("after_abort_sum", sum4, 11);
    chk("after_abort_lat", lat, 4);

    op4(4'd15, 4'd0, 1'b1, 1'b0, lat, nbusy);
    chk("cin_sum",  sum4, CIN_EN ? 0 : 15);
    chk("cin_cout", cout4, CIN_EN ? 1 : 0);

    // WIDTH=1, all combinations
    for (int i = 0; i < 4; i++) begin
      logic av, bv;
      av = (i & 1) != 0;
      bv = (i & 2) != 0;
      op1(av, bv, lat);
      chk("w1_lat", lat, 1);
      chk("w1_sum", sum1, av ^ bv);
      chk("w1_cout", cout1, av & bv);
    end

    // random traffic on both instances
    repeat (800) begin
      @(negedge clk);
      start4 = 1'($urandom_range(0, 2) == 0);
      start1 = 1'($urandom_range(0, 1));
      a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
      a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
      rst = ($urandom_range(0, 60) == 0);
    end
    @(negedge clk);
    rst = 1'b0; start4 = 1'b0; start1 = 1'b0;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001: Parameter WIDTH, default 4, operand and sum width in bits; legal range 1..64.
REQ-002: clk  input  1  single clock; all state updates on the rising edge.
REQ-003: rst  input  1  reset, synchronous and active-high.
REQ-004: start  input  1  request a new addition; sampled only in IDLE.
REQ-005: a  input  WIDTH  operand A, captured on the accepted start edge.
REQ-006: b  input  WIDTH  operand B, captured on the accepted start edge.
REQ-007: cin  input  1  carry-in, captured with the operands; present only when SERIAL_ADDER_CIN_EN is defined.
REQ-008: busy  output  1  high while bit-serial addition is in progress (RUN).
REQ-009: done  output  1  one-cycle pulse; sum and cout are valid and newly updated.
REQ-010: sum  output  WIDTH  registered result, a+b(+cin) mod 2^WIDTH.
REQ-011: cout  output  1  registered carry out of bit WIDTH-1.

Function
REQ-012: The FSM SHALL have states IDLE, RUN and DONE; reset state is IDLE.
REQ-013: IDLE with start=1 at edge k: load a and b into shift registers, load carry (cin or 0), clear bit counter, go to RUN.
REQ-014: RUN: each edge SHALL add operand LSBs plus carry (full-adder), shift the sum bit into a sum shift register from the MSB side, shift operands right, update carry, increment counter.
REQ-015: After the WIDTH-th bit edge (edge k+WIDTH), the FSM SHALL enter DONE and copy the sum shift register to sum and the final carry to cout.
REQ-016: done SHALL be high for exactly the one cycle in DONE; the next edge returns to IDLE unconditionally.
REQ-017: Latency: start sampled at edge k -> done visible after edge k+WIDTH, for one cycle; throughput one result per WIDTH+2 cycles.
REQ-018: busy SHALL equal (state==RUN); busy and done are never high together.
REQ-019: start in RUN or DONE SHALL be ignored; no queuing, and operands are not re-sampled.
REQ-020: Changes on a/b/cin after the accepted start SHALL NOT affect the result.
REQ-021: sum and cout SHALL hold their last values from DONE until the next operation's DONE; they do not change during RUN.
REQ-022: Bit counter width SHALL be clog2(WIDTH+1); WIDTH=1 completes after one RUN edge.

Reset
REQ-023: rst=1 at an edge SHALL force IDLE, clear shift registers, carry and counter, and set busy=0, done=0, sum=0, cout=0.
REQ-024: Reset during RUN or DONE SHALL abort the operation without producing a done pulse; rst has priority over start.

Configuration
REQ-025: Macro SERIAL_ADDER_CIN_EN defined: the cin port exists and its value seeds the carry register at start.
REQ-026: Macro undefined: no cin port; the carry register is seeded with 0, and the result is a+b.

Verification
REQ-027: WIDTH=4, a=7, b=9, start at edge k -> busy for 4 cycles, done after edge k+4, sum=0, cout=1.
REQ-028: WIDTH=4, a=15, b=15 -> sum=14, cout=1; then a=3, b=4 -> sum=7, cout=0; outputs hold between operations.
REQ-029: WIDTH=4, start held high during RUN with a new a=1, b=1 -> first result unchanged, one done pulse only, FSM returns to IDLE.
REQ-030: rst asserted at the 2nd RUN edge -> next cycle IDLE, all outputs 0, no done pulse; a new start afterwards completes normally.
REQ-031: SERIAL_ADDER_CIN_EN defined, WIDTH=4, a=15, b=0, cin=1 -> sum=0, cout=1; undefined build, a=15, b=0 -> sum=15, cout=0.
REQ-032: WIDTH=1, all four a/b combinations -> sum=a^b, cout=a&b, done after edge k+1.
